// File: rtl/key_expansion_multi.sv
// Multi-context AES-128/192/256 key expander: stores complete round-key schedules for NUM_SLOTS contexts.
// Latency: one word expanded per cycle (40/46/52 cycles after the final key beat); reads return after 1 cycle.
// Backpressure: key_in_ready drops for the whole of EXPAND; the read port never stalls.
module key_expansion_multi #(
    parameter int NUM_SLOTS = 2,
    localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 key_in_valid,
    output logic                 key_in_ready,
    input  logic [1:0]           key_in_type,
    input  logic [SW-1:0]        key_in_slot,
    input  logic [127:0]         key_in,
    input  logic                 rd_en,
    input  logic [SW-1:0]        rd_slot,
    input  logic [3:0]           rd_addr,
    output logic [127:0]         key_out,
    output logic                 key_out_valid,
    output logic [NUM_SLOTS-1:0] key_loaded,
    output logic                 busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BEAT2  = 2'd1,
        ST_EXPAND = 2'd2
    } state_t;

    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TBL[2047 - 8*int'(x) -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] t);
        case (t)
            2'b00:   return 4'd10;
            2'b01:   return 4'd12;
            2'b10:   return 4'd14;
            default: return 4'd0;
        endcase
    endfunction

    // Schedule storage and per-slot stored type; neither is reset.
    logic [127:0] key_mem       [NUM_SLOTS][15];
    logic [1:0]   slot_type_mem [NUM_SLOTS];

    state_t                state_q, state_d;
    logic [1:0]            type_q, type_d;
    logic [SW-1:0]         slot_q, slot_d;
    logic [5:0]            word_q, word_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [7:0]            rcon_q, rcon_d;
    logic [31:0]           win_q [8];
    logic [31:0]           win_d [8];
    logic [NUM_SLOTS-1:0]  key_loaded_q, key_loaded_d;
    logic [NUM_SLOTS-1:0]  written_q, written_d;
    logic [127:0]          key_out_q, key_out_d;
    logic                  key_out_valid_q, key_out_valid_d;

    logic                  mem_we;
    logic [SW-1:0]         mem_slot;
    logic [3:0]            mem_row;
    logic [3:0]            mem_mask;
    logic [127:0]          mem_dat;
    logic                  st_we;
    logic                  accept;
    logic                  slot_ok;
    logic [2:0]            nk_last;
    logic [5:0]            last_word;
    logic [31:0]           temp;
    logic [31:0]           new_word;
    logic                  rd_ok;
    logic [127:0]          rd_dat;

    always_comb begin
        state_d      = state_q;
        type_d       = type_q;
        slot_d       = slot_q;
        word_d       = word_q;
        cnt_d        = cnt_q;
        rcon_d       = rcon_q;
        win_d        = win_q;
        key_loaded_d = key_loaded_q;
        written_d    = written_q;
        mem_we       = 1'b0;
        mem_slot     = slot_q;
        mem_row      = 4'd0;
        mem_mask     = 4'b0000;
        mem_dat      = '0;
        st_we        = 1'b0;
        temp         = '0;
        new_word     = '0;

        case (type_q)
            2'b01:   begin nk_last = 3'd5; last_word = 6'd51; end
            2'b10:   begin nk_last = 3'd7; last_word = 6'd59; end
            default: begin nk_last = 3'd3; last_word = 6'd43; end
        endcase

        key_in_ready = (state_q != ST_EXPAND);
        accept       = key_in_valid && key_in_ready;
        slot_ok      = int'(key_in_slot) < NUM_SLOTS;

        case (state_q)
            ST_IDLE: begin
                // Reserved type (or a nonexistent slot) is consumed without side effects.
                if (accept && key_in_type != 2'b11 && slot_ok) begin
                    type_d   = key_in_type;
                    slot_d   = key_in_slot;
                    mem_we   = 1'b1;
                    mem_slot = key_in_slot;
                    mem_mask = 4'b1111;
                    mem_dat  = key_in;
                    st_we    = 1'b1;
                    key_loaded_d[key_in_slot] = 1'b0;
                    written_d[key_in_slot]    = 1'b1;
                    for (int k = 0; k < 4; k++) win_d[k] = key_in[32*k +: 32];
                    rcon_d = 8'h01;
                    cnt_d  = 3'd0;
                    if (key_in_type == 2'b00) begin
                        state_d = ST_EXPAND;
                        word_d  = 6'd4;
                    end else begin
                        state_d = ST_BEAT2;
                    end
                end
            end
            ST_BEAT2: begin
                if (accept) begin
                    mem_we  = 1'b1;
                    mem_row = 4'd1;
                    mem_dat = key_in;
                    state_d = ST_EXPAND;
                    if (type_q == 2'b10) begin
                        mem_mask = 4'b1111;
                        for (int k = 0; k < 4; k++) begin
                            win_d[k+4] = win_q[k];
                            win_d[k]   = key_in[32*k +: 32];
                        end
                        word_d = 6'd8;
                    end else begin
                        mem_mask = 4'b0011;
                        for (int k = 0; k < 6; k++) win_d[k+2] = win_q[k];
                        win_d[1] = key_in[127:96];
                        win_d[0] = key_in[95:64];
                        word_d   = 6'd6;
                    end
                end
            end
            ST_EXPAND: begin
                // win_q[0] is w[i-1]; win_q[nk_last] is w[i-Nk].
                temp = win_q[0];
                if (cnt_q == 3'd0) begin
                    temp   = sub_word({win_q[0][23:0], win_q[0][31:24]}) ^ {rcon_q, 24'h0};
                    rcon_d = xtime(rcon_q);
                end else if (type_q == 2'b10 && cnt_q == 3'd4) begin
                    temp = sub_word(win_q[0]);
                end
                new_word = win_q[nk_last] ^ temp;
                for (int k = 7; k > 0; k--) win_d[k] = win_q[k-1];
                win_d[0] = new_word;
                mem_we   = 1'b1;
                mem_row  = word_q[5:2];
                mem_mask = 4'b0001 << word_q[1:0];
                mem_dat  = {4{new_word}};
                word_d   = word_q + 6'd1;
                cnt_d    = (cnt_q == nk_last) ? 3'd0 : cnt_q + 3'd1;
                if (word_q == last_word) begin
                    key_loaded_d[slot_q] = 1'b1;
                    state_d              = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_ok  = 1'b0;
        rd_dat = '0;
        if (int'(rd_slot) < NUM_SLOTS) begin
            rd_ok = written_q[rd_slot] && (rd_addr <= nr_of(slot_type_mem[rd_slot]));
        end
        if (rd_ok) rd_dat = key_mem[rd_slot][rd_addr];
        key_out_d       = rd_en ? rd_dat : key_out_q;
        key_out_valid_d = rd_en;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int l = 0; l < 4; l++) begin
                if (mem_mask[l]) key_mem[mem_slot][mem_row][127-32*l -: 32] <= mem_dat[127-32*l -: 32];
            end
        end
        if (st_we) slot_type_mem[mem_slot] <= type_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= ST_IDLE;
            type_q          <= 2'b00;
            slot_q          <= '0;
            word_q          <= '0;
            cnt_q           <= '0;
            rcon_q          <= 8'h01;
            for (int k = 0; k < 8; k++) win_q[k] <= '0;
            key_loaded_q    <= '0;
            written_q       <= '0;
            key_out_q       <= '0;
            key_out_valid_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            type_q          <= type_d;
            slot_q          <= slot_d;
            word_q          <= word_d;
            cnt_q           <= cnt_d;
            rcon_q          <= rcon_d;
            win_q           <= win_d;
            key_loaded_q    <= key_loaded_d;
            written_q       <= written_d;
            key_out_q       <= key_out_d;
            key_out_valid_q <= key_out_valid_d;
        end
    end

    assign key_out       = key_out_q;
    assign key_out_valid = key_out_valid_q;
    assign key_loaded    = key_loaded_q;
    assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_key_expansion_multi.sv
// Bench for key_expansion_multi: FIPS-197 vectors plus an independent GF(2^8) key-schedule model.
module tb_key_expansion_multi;

    localparam logic [127:0] K128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [191:0] K192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    logic         clk = 1'b0;
    logic         rst;
    logic         key_in_valid;
    logic         key_in_ready;
    logic [1:0]   key_in_type;
    logic         key_in_slot;
    logic [127:0] key_in;
    logic         rd_en;
    logic         rd_slot;
    logic [3:0]   rd_addr;
    logic [127:0] key_out;
    logic         key_out_valid;
    logic [1:0]   key_loaded;
    logic         busy;

    int n_checks = 0;
    int n_errors = 0;
    int n_push   = 0;
    int n_pop    = 0;

    logic [127:0] exp_q[$];
    string        tag_q[$];
    logic [127:0] sb_exp;
    string        sb_tag;
    logic [127:0] last_exp;

    logic [7:0]  tb_sb [256];
    logic [31:0] mw [3][60];

    key_expansion_multi #(.NUM_SLOTS(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .key_in_valid (key_in_valid),
        .key_in_ready (key_in_ready),
        .key_in_type  (key_in_type),
        .key_in_slot  (key_in_slot),
        .key_in       (key_in),
        .rd_en        (rd_en),
        .rd_slot      (rd_slot),
        .rd_addr      (rd_addr),
        .key_out      (key_out),
        .key_out_valid(key_out_valid),
        .key_loaded   (key_loaded),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int k = 0; k < 8; k++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    task automatic init_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            if (x != 0) begin
                inv = 8'h01;
                for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
            end
            tb_sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                           ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] tb_subw(input logic [31:0] w);
        return {tb_sb[w[31:24]], tb_sb[w[23:16]], tb_sb[w[15:8]], tb_sb[w[7:0]]};
    endfunction

    task automatic model_expand(input int m, input logic [255:0] key, input int nk);
        int         nw;
        logic [31:0] t;
        logic [7:0]  rc;
        nw = (nk == 4) ? 44 : (nk == 6) ? 52 : 60;
        for (int i = 0; i < nk; i++) mw[m][i] = key[255-32*i -: 32];
        rc = 8'h01;
        for (int i = nk; i < nw; i++) begin
            t = mw[m][i-1];
            if (i % nk == 0) begin
                t  = tb_subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end else if (nk == 8 && i % 8 == 4) begin
                t = tb_subw(t);
            end
            mw[m][i] = mw[m][i-nk] ^ t;
        end
    endtask

    function automatic logic [127:0] exp_round(input int m, input int r, input int nr);
        if (r > nr) return '0;
        return {mw[m][4*r], mw[m][4*r+1], mw[m][4*r+2], mw[m][4*r+3]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [1:0] typ, input logic sl, input logic [127:0] k);
        key_in_valid = 1'b1;
        key_in_type  = typ;
        key_in_slot  = sl;
        key_in       = k;
        check("rdy_before_beat", 128'(key_in_ready), 128'd1);
        tick();
        key_in_valid = 1'b0;
    endtask

    task automatic read_req(input logic sl, input logic [3:0] a, input logic [127:0] e, input string t);
        rd_en   = 1'b1;
        rd_slot = sl;
        rd_addr = a;
        exp_q.push_back(e);
        tag_q.push_back(t);
        n_push++;
        last_exp = e;
    endtask

    task automatic read_one(input logic sl, input logic [3:0] a, input logic [127:0] e, input string t);
        read_req(sl, a, e, t);
        tick();
        rd_en = 1'b0;
        tick();
    endtask

    // Counts edges after the final key beat; the flag must rise exactly on edge n.
    task automatic wait_load(input int sl, input int n, input string tg);
        logic rdy_seen;
        rdy_seen = 1'b0;
        for (int c = 1; c <= n; c++) begin
            tick();
            if (c < n) rdy_seen = rdy_seen | key_in_ready;
            if (c == n - 1) check({tg, "_loaded_early"}, 128'(key_loaded[sl]), 128'd0);
        end
        check({tg, "_loaded"}, 128'(key_loaded[sl]), 128'd1);
        check({tg, "_busy_done"}, 128'(busy), 128'd0);
        check({tg, "_rdy_done"}, 128'(key_in_ready), 128'd1);
        check({tg, "_rdy_low_expand"}, 128'(rdy_seen), 128'd0);
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1 && key_out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 128'(exp_q.size()), 128'd1);
            end else begin
                sb_exp = exp_q.pop_front();
                sb_tag = tag_q.pop_front();
                n_pop++;
                check(sb_tag, key_out, sb_exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic rdy_seen;
        logic vld_all;

        rst = 1'b0;
        key_in_valid = 1'b0;
        key_in_type  = 2'b00;
        key_in_slot  = 1'b0;
        key_in       = '0;
        rd_en        = 1'b0;
        rd_slot      = 1'b0;
        rd_addr      = 4'd0;
        last_exp     = '0;

        init_sbox();
        model_expand(0, {K128, 128'h0}, 4);
        model_expand(1, {K192, 64'h0}, 6);
        model_expand(2, K256, 8);

        #12;
        check("rst_key_out", key_out, 128'd0);
        check("rst_key_out_valid", 128'(key_out_valid), 128'd0);
        check("rst_key_loaded", 128'(key_loaded), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_ready", 128'(key_in_ready), 128'd1);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // AES-128 into slot 0
        send_beat(2'b00, 1'b0, K128);
        check("k128_loaded_clear", 128'(key_loaded[0]), 128'd0);
        check("k128_busy", 128'(busy), 128'd1);
        wait_load(0, 40, "k128");
        read_one(1'b0, 4'd1, 128'ha0fafe1788542cb123a339392a6c7605, "k128_round1");
        read_one(1'b0, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "k128_round10");
        read_one(1'b0, 4'd0, exp_round(0, 0, 10), "k128_round0");
        read_one(1'b0, 4'd11, 128'd0, "k128_round11_zero");

        // AES-192 into slot 1; beat 2 carries a bogus type/slot and junk low half
        send_beat(2'b01, 1'b1, K192[191:64]);
        check("k192_busy_beat2", 128'(busy), 128'd1);
        repeat (3) tick();
        check("k192_busy_idle", 128'(busy), 128'd1);
        check("k192_rdy_idle", 128'(key_in_ready), 128'd1);
        send_beat(2'b11, 1'b0, {K192[63:0], 64'hdeadbeef0badf00d});
        wait_load(1, 46, "k192");
        read_one(1'b1, 4'd12, 128'he98ba06f448c773c8ecc720401002202, "k192_round12");
        read_one(1'b1, 4'd13, 128'd0, "k192_round13_zero");
        read_one(1'b1, 4'd5, exp_round(1, 5, 12), "k192_round5");

        // reserved type is swallowed
        send_beat(2'b11, 1'b0, K128 ^ 128'h1);
        check("rsv_busy", 128'(busy), 128'd0);
        check("rsv_loaded", 128'(key_loaded), 128'd3);
        tick();
        check("rsv_busy_later", 128'(busy), 128'd0);

        // AES-256 into slot 1 while key_in_valid is held and slot 0 is read every cycle
        send_beat(2'b10, 1'b1, K256[255:128]);
        send_beat(2'b00, 1'b0, K256[127:0]);
        key_in_valid = 1'b1;
        key_in_type  = 2'b11;
        key_in       = '0;
        rdy_seen = 1'b0;
        vld_all  = 1'b1;
        for (int c = 1; c <= 52; c++) begin
            read_req(1'b0, 4'(c % 11), exp_round(0, c % 11, 10), "b2b_slot0");
            tick();
            vld_all = vld_all & key_out_valid;
            if (c < 52) rdy_seen = rdy_seen | key_in_ready;
            if (c == 51) check("k256_loaded_early", 128'(key_loaded[1]), 128'd0);
        end
        rd_en = 1'b0;
        check("k256_loaded", 128'(key_loaded[1]), 128'd1);
        check("k256_rdy_low_expand", 128'(rdy_seen), 128'd0);
        check("k256_rdy_done", 128'(key_in_ready), 128'd1);
        check("b2b_valid_every_cycle", 128'(vld_all), 128'd1);
        tick();
        key_in_valid = 1'b0;
        check("held_beat_discarded", 128'(busy), 128'd0);
        check("idle_valid_low", 128'(key_out_valid), 128'd0);
        check("idle_key_out_hold", key_out, last_exp);
        read_one(1'b1, 4'd14, 128'hfe4890d1e6188d0b046df344706c631e, "k256_round14");
        read_one(1'b1, 4'd7, exp_round(2, 7, 14), "k256_round7");
        read_one(1'b0, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "slot0_unchanged");

        // reload slot 0, then asynchronous reset mid-expansion
        send_beat(2'b00, 1'b0, K128 ^ 128'h0123456789abcdef);
        check("reload_flag_drop", 128'(key_loaded), 128'd2);
        repeat (10) tick();
        #3;
        rst = 1'b0;
        #1;
        check("arst_loaded", 128'(key_loaded), 128'd0);
        check("arst_busy", 128'(busy), 128'd0);
        check("arst_ready", 128'(key_in_ready), 128'd1);
        check("arst_key_out", key_out, 128'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // recovery after reset
        send_beat(2'b00, 1'b1, K128);
        wait_load(1, 40, "post_rst");
        read_one(1'b1, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "post_rst_round10");
        read_one(1'b1, 4'd11, 128'd0, "post_rst_round11_zero");

        check("sb_drained", 128'(exp_q.size()), 128'd0);
        check("sb_count", 128'(n_pop), 128'(n_push));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
